sc_unit_sequencer: RTL and testbench
====================================

// Module: sc_unit_sequencer
// PURPOSE
//  Sequences the shared complex integer unit (SC unit: bitmanip/shift-class uops flagged sc=1 at decode).
//  Arbitrates two integer issue lanes onto the single SC unit and keeps one op in flight.
//  Holds the SC unit's result for the writeback port and discards stale results after a flush.
//  Sits between the integer issue queues and the SC unit, and feeds the integer writeback mux.
// PARAMETERS
//  XLEN   32  operand/result width
//  TAG_W  6   physical destination tag width
// PORTS
//  cpu_clock_i    in   1      core clock
//  cpu_reset_i    in   1      reset
//  flush_i        in   1      pipeline flush; kills the in-flight op
//  req0_valid_i   in   1      lane 0 has an SC op
//  req0_uop_i     in   7      lane 0 decoded uop
//  req0_a_i       in   XLEN   lane 0 operand A
//  req0_b_i       in   XLEN   lane 0 operand B/immediate
//  req0_tag_i     in   TAG_W  lane 0 destination tag
//  req0_ready_o   out  1      lane 0 op accepted this cycle
//  req1_*         --   --     same set as req0_* for lane 1
//  cu_valid_o     out  1      op presented to SC unit
//  cu_uop_o       out  7      registered uop
//  cu_a_o         out  XLEN   registered operand A
//  cu_b_o         out  XLEN   registered operand B
//  cu_ready_i     in   1      SC unit accepts op
//  cu_done_i      in   1      SC unit result valid (1 cycle pulse)
//  cu_result_i    in   XLEN   SC unit result
//  wb_valid_o     out  1      result available for writeback
//  wb_tag_o       out  TAG_W  destination tag
//  wb_data_o      out  XLEN   result data
//  wb_ready_i     in   1      writeback accepted
// BEHAVIOUR
//  Clocking/reset: one clock; reset is asynchronous and active-high.
//  All outputs are 0 at reset. State=IDLE. Arbiter pointer=lane 0.
//  FSM: IDLE -> ISSUE -> WAIT -> WB -> IDLE, plus DRAIN.
//   IDLE: reqN_ready_o=1 for the granted lane only, and only when !flush_i.
//         On grant, register uop, a, b and tag, then go to ISSUE. Operands are never sampled at any other time.
//   ISSUE: cu_valid_o=1 and the payload is held stable until cu_ready_i.
//          cu_ready_i -> WAIT. cu_done_i in the same cycle as cu_ready_i (1-cycle unit) -> WB directly.
//   WAIT: on cu_done_i, capture cu_result_i into wb_data_o and go to WB.
//   WB: wb_valid_o=1 with tag and data held stable until wb_ready_i, then IDLE.
//       No new grant in that cycle; there is a 1-cycle bubble.
//   DRAIN: entered on flush_i during WAIT, or during ISSUE in the cycle cu_ready_i=1.
//          Wait for cu_done_i, drop the result, then go to IDLE.
//  flush_i in ISSUE without cu_ready_i: drop cu_valid_o next cycle and go to IDLE.
//  flush_i in WB: drop wb_valid_o next cycle and go to IDLE.
//  flush_i in DRAIN: stay in DRAIN.
//  flush_i with cu_done_i in the same cycle (WAIT or DRAIN): go to IDLE; the result is discarded.
//  Only one op is in flight at a time. Throughput is at most 1 op per 3 cycles (1-cycle unit, wb_ready_i=1).
//  A lane's request is held until its ready_o is seen. Loser lane: ready_o=0, nothing is consumed.
//  cu_done_i outside WAIT, DRAIN and ISSUE(+cu_ready_i) is a protocol error. Flag it with an assertion and ignore it.
// CONFIGURATION
//  SC_ARB_FAIR_EN defined: round-robin arbitration.
//   When both lanes request, grant the lane not granted last. Pointer updates on every grant.
//  Not defined: fixed priority, lane 0 always wins. The pointer register is not built.
// STRUCTURE
//  Shared package: SC uop encodings (CPOP, CLZ, CTZ, ROR, ...), sc_seq_state_t enum
//   (IDLE, ISSUE, WAIT, WB, DRAIN), XLEN/TAG_W defaults.
//  Sub-module: sc_rr_arbiter. 2-way grant with an optional pointer; purely combinational grant, registered pointer.
// TESTING
//  1. Lane 0 only: uop=CPOP, a=0x0000_00FF, tag=5. cu_ready_i immediate, done after 3 cycles, result=8, wb_ready_i=1
//     -> wb_valid_o with tag=5, data=8; req0_ready_o high exactly 1 cycle.
//  2. Both lanes request every cycle for 4 ops, FAIR_EN on -> grants 0,1,0,1.
//     FAIR_EN off -> grants 0,0,0,0 and req1_ready_o stays 0.
//  3. cu_ready_i held 0 for 5 cycles in ISSUE -> cu_valid_o and payload stable for 5 cycles, then WAIT.
//  4. flush_i 1 cycle into WAIT, done 2 cycles later with result 0xDEAD -> wb_valid_o never asserts.
//     A new grant occurs only after cu_done_i.
//  5. wb_ready_i low for 4 cycles -> wb_valid/tag/data held; no req*_ready_o until 1 cycle after acceptance.
//  6. cpu_reset_i asserted in WAIT -> all outputs 0 immediately; IDLE; pointer=lane 0.

Source files
------------

// File: rtl/sc_unit_sequencer_pkg.sv
// Shared types for the SC unit sequencer: uop encodings, FSM states, widths.
package sc_unit_sequencer_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int UOP_W = 7;

    typedef logic [UOP_W-1:0] sc_uop_t;

    localparam sc_uop_t UOP_CPOP = 7'h01;
    localparam sc_uop_t UOP_CLZ  = 7'h02;
    localparam sc_uop_t UOP_CTZ  = 7'h03;
    localparam sc_uop_t UOP_ROR  = 7'h04;
    localparam sc_uop_t UOP_ROL  = 7'h05;
    localparam sc_uop_t UOP_REV8 = 7'h06;
    localparam sc_uop_t UOP_ORCB = 7'h07;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        DRAIN
    } sc_seq_state_t;

endpackage

// File: rtl/sc_unit_sequencer_if.sv
// Issue-lane, SC-unit and writeback signals of the sequencer.
interface sc_unit_sequencer_if;
    import sc_unit_sequencer_pkg::*;

    logic             flush_i;
    logic             req0_valid_i;
    sc_uop_t          req0_uop_i;
    logic [XLEN-1:0]  req0_a_i;
    logic [XLEN-1:0]  req0_b_i;
    logic [TAG_W-1:0] req0_tag_i;
    logic             req0_ready_o;
    logic             req1_valid_i;
    sc_uop_t          req1_uop_i;
    logic [XLEN-1:0]  req1_a_i;
    logic [XLEN-1:0]  req1_b_i;
    logic [TAG_W-1:0] req1_tag_i;
    logic             req1_ready_o;
    logic             cu_valid_o;
    sc_uop_t          cu_uop_o;
    logic [XLEN-1:0]  cu_a_o;
    logic [XLEN-1:0]  cu_b_o;
    logic             cu_ready_i;
    logic             cu_done_i;
    logic [XLEN-1:0]  cu_result_i;
    logic             wb_valid_o;
    logic [TAG_W-1:0] wb_tag_o;
    logic [XLEN-1:0]  wb_data_o;
    logic             wb_ready_i;

    modport slave (
        input  flush_i,
        input  req0_valid_i, req0_uop_i, req0_a_i, req0_b_i, req0_tag_i,
        output req0_ready_o,
        input  req1_valid_i, req1_uop_i, req1_a_i, req1_b_i, req1_tag_i,
        output req1_ready_o,
        output cu_valid_o, cu_uop_o, cu_a_o, cu_b_o,
        input  cu_ready_i, cu_done_i, cu_result_i,
        output wb_valid_o, wb_tag_o, wb_data_o,
        input  wb_ready_i
    );

    modport master (
        output flush_i,
        output req0_valid_i, req0_uop_i, req0_a_i, req0_b_i, req0_tag_i,
        input  req0_ready_o,
        output req1_valid_i, req1_uop_i, req1_a_i, req1_b_i, req1_tag_i,
        input  req1_ready_o,
        input  cu_valid_o, cu_uop_o, cu_a_o, cu_b_o,
        output cu_ready_i, cu_done_i, cu_result_i,
        input  wb_valid_o, wb_tag_o, wb_data_o,
        output wb_ready_i
    );

endinterface

// File: rtl/sc_unit_sequencer_arb.sv
// 2-way lane arbiter. SC_ARB_FAIR_EN selects round-robin with a registered
// pointer; otherwise lane 0 has fixed priority and no pointer exists.
module sc_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef SC_ARB_FAIR_EN
    // ptr names the lane that wins a tie; it moves off whichever lane won
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ptr <= 1'b0;
        else if (|gnt) ptr <= gnt[0];
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        gnt = 2'b00;
        if (en) gnt = {req[1] & ~req[0], req[0]};
    end
`endif

endmodule

// File: rtl/sc_unit_sequencer.sv
// Issues one SC op at a time from two lanes and holds its result for writeback.
// Arbitration mode is set by SC_ARB_FAIR_EN (see sc_rr_arbiter).
module sc_unit_sequencer
    import sc_unit_sequencer_pkg::*;
(
    input logic                cpu_clock_i,
    input logic                cpu_reset_i,
    sc_unit_sequencer_if.slave bus
);

    sc_seq_state_t    state, state_nxt;
    logic [1:0]       req, gnt;
    logic             arb_en, take, cu_fire, capture;
    logic             cu_valid, wb_valid;
    sc_uop_t          uop_q;
    logic [XLEN-1:0]  a_q, b_q, data_q;
    logic [TAG_W-1:0] tag_q;

    assign req     = {bus.req1_valid_i, bus.req0_valid_i};
    assign arb_en  = (state == IDLE) && !bus.flush_i && !cpu_reset_i;
    assign take    = |gnt;
    assign cu_fire = (state == ISSUE) && bus.cu_ready_i;
    assign capture = bus.cu_done_i && !bus.flush_i
                   && ((state == WAIT) || cu_fire);

    sc_rr_arbiter u_arb (
        .clk (cpu_clock_i),
        .rst (cpu_reset_i),
        .en  (arb_en),
        .req (req),
        .gnt (gnt)
    );

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (take) state_nxt = ISSUE;
            ISSUE: begin
                if (bus.cu_ready_i) begin
                    if (bus.cu_done_i) state_nxt = bus.flush_i ? IDLE : WB;
                    else               state_nxt = bus.flush_i ? DRAIN : WAIT;
                end else if (bus.flush_i) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (bus.cu_done_i)    state_nxt = bus.flush_i ? IDLE : WB;
                else if (bus.flush_i) state_nxt = DRAIN;
            end
            WB:    if (bus.flush_i || bus.wb_ready_i) state_nxt = IDLE;
            DRAIN: if (bus.cu_done_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cu_valid = 1'b0;
        wb_valid = 1'b0;
        unique case (state)
            ISSUE:   cu_valid = 1'b1;
            WB:      wb_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands are sampled only on a grant; the result only when not flushed
    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            uop_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            if (take) begin
                uop_q <= gnt[1] ? bus.req1_uop_i : bus.req0_uop_i;
                a_q   <= gnt[1] ? bus.req1_a_i   : bus.req0_a_i;
                b_q   <= gnt[1] ? bus.req1_b_i   : bus.req0_b_i;
                tag_q <= gnt[1] ? bus.req1_tag_i : bus.req0_tag_i;
            end
            if (capture) data_q <= bus.cu_result_i;
        end
    end

    assign bus.req0_ready_o = gnt[0];
    assign bus.req1_ready_o = gnt[1];
    assign bus.cu_valid_o   = cu_valid;
    assign bus.cu_uop_o     = uop_q;
    assign bus.cu_a_o       = a_q;
    assign bus.cu_b_o       = b_q;
    assign bus.wb_valid_o   = wb_valid;
    assign bus.wb_tag_o     = tag_q;
    assign bus.wb_data_o    = data_q;

    // A done pulse with no op at the unit is ignored by the FSM above
    a_done_protocol: assert property (
        @(posedge cpu_clock_i) disable iff (cpu_reset_i)
        bus.cu_done_i |-> (state == WAIT || state == DRAIN || cu_fire)
    );

endmodule

// File: tb/tb_sc_unit_sequencer.sv
// Directed bench for sc_unit_sequencer; expectations follow SC_ARB_FAIR_EN.
module tb_sc_unit_sequencer;
    import sc_unit_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   errs = 0;
    int   ncyc = 0;
    int   r0_cnt = 0;
    int   r1_cnt = 0;
    int   gn = 0;
    logic glane [64];
    int   gcyc  [64];

    sc_unit_sequencer_if bus ();

    sc_unit_sequencer dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc++;
        if (bus.req0_ready_o) r0_cnt++;
        if (bus.req1_ready_o) r1_cnt++;
        if ((bus.req0_ready_o || bus.req1_ready_o) && gn < 64) begin
            glane[gn] = bus.req1_ready_o;
            gcyc[gn]  = ncyc;
            gn++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input sc_uop_t u, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] t);
        bus.req0_uop_i = u; bus.req0_a_i = a;
        bus.req0_b_i = b;   bus.req0_tag_i = t;
    endtask

    task automatic drive1(input sc_uop_t u, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] t);
        bus.req1_uop_i = u; bus.req1_a_i = a;
        bus.req1_b_i = b;   bus.req1_tag_i = t;
    endtask

    task automatic test_reset();
        bus.req0_valid_i = 1'b1;
        cyc(); cyc();
        vec++; if (bus.req0_ready_o !== 1'b0) begin errs++; $display("FAIL rst_ready0 got %b want 0", bus.req0_ready_o); end
        vec++; if (bus.cu_valid_o !== 1'b0) begin errs++; $display("FAIL rst_cu_valid got %b want 0", bus.cu_valid_o); end
        vec++; if (bus.wb_valid_o !== 1'b0) begin errs++; $display("FAIL rst_wb_valid got %b want 0", bus.wb_valid_o); end
        vec++; if (bus.cu_a_o !== 32'h0) begin errs++; $display("FAIL rst_cu_a got %h want 0", bus.cu_a_o); end
        vec++; if (bus.wb_tag_o !== 6'h0) begin errs++; $display("FAIL rst_wb_tag got %h want 0", bus.wb_tag_o); end
        bus.req0_valid_i = 1'b0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_lane0();
        int c0;
        c0 = r0_cnt;
        drive0(UOP_CPOP, 32'h0000_00FF, 32'h0, 6'd5);
        bus.req0_valid_i = 1'b1;
        #1;
        vec++; if (bus.req0_ready_o !== 1'b1) begin errs++; $display("FAIL t1_ready0 got %b want 1", bus.req0_ready_o); end
        cyc();
        bus.req0_valid_i = 1'b0;
        vec++; if (bus.cu_valid_o !== 1'b1) begin errs++; $display("FAIL t1_cu_valid got %b want 1", bus.cu_valid_o); end
        vec++; if (bus.cu_uop_o !== UOP_CPOP) begin errs++; $display("FAIL t1_cu_uop got %h want %h", bus.cu_uop_o, UOP_CPOP); end
        vec++; if (bus.cu_a_o !== 32'h0000_00FF) begin errs++; $display("FAIL t1_cu_a got %h want 000000ff", bus.cu_a_o); end
        cyc(); cyc(); cyc();
        bus.cu_done_i = 1'b1; bus.cu_result_i = 32'd8;
        cyc();
        bus.cu_done_i = 1'b0;
        vec++; if (bus.wb_valid_o !== 1'b1) begin errs++; $display("FAIL t1_wb_valid got %b want 1", bus.wb_valid_o); end
        vec++; if (bus.wb_tag_o !== 6'd5) begin errs++; $display("FAIL t1_wb_tag got %0d want 5", bus.wb_tag_o); end
        vec++; if (bus.wb_data_o !== 32'd8) begin errs++; $display("FAIL t1_wb_data got %0d want 8", bus.wb_data_o); end
        cyc();
        vec++; if (bus.wb_valid_o !== 1'b0) begin errs++; $display("FAIL t1_wb_drop got %b want 0", bus.wb_valid_o); end
        vec++; if (r0_cnt - c0 !== 1) begin errs++; $display("FAIL t1_ready0_cycles got %0d want 1", r0_cnt - c0); end
    endtask

    task automatic test_arbitration();
        int g0, c1, k, want_r1;
        logic [3:0] exp_l;
        logic [5:0] exp_tag;
`ifdef SC_ARB_FAIR_EN
        exp_l = 4'b1010; want_r1 = 2; exp_tag = 6'd11;
`else
        exp_l = 4'b0000; want_r1 = 0; exp_tag = 6'd10;
`endif
        g0 = gn; c1 = r1_cnt; k = 0;
        drive0(UOP_CLZ, 32'h1, 32'h0, 6'd10);
        drive1(UOP_CTZ, 32'h2, 32'h0, 6'd11);
        bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
        bus.cu_result_i = 32'h55;
        while (gn - g0 < 4 && k < 40) begin
            cyc();
            bus.cu_done_i = bus.cu_valid_o;
            k++;
        end
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        cyc();
        bus.cu_done_i = bus.cu_valid_o;
        vec++; if (bus.wb_tag_o !== exp_tag) begin errs++; $display("FAIL t2_last_tag got %0d want %0d", bus.wb_tag_o, exp_tag); end
        cyc();
        vec++; if (gn - g0 !== 4) begin errs++; $display("FAIL t2_grant_count got %0d want 4", gn - g0); end
        for (int j = 0; j < 4; j++) begin
            vec++; if (glane[g0+j] !== exp_l[j]) begin errs++; $display("FAIL t2_lane%0d got %b want %b", j, glane[g0+j], exp_l[j]); end
        end
        for (int j = 1; j < 4; j++) begin
            vec++; if (gcyc[g0+j] - gcyc[g0+j-1] !== 3) begin errs++; $display("FAIL t2_spacing%0d got %0d want 3", j, gcyc[g0+j] - gcyc[g0+j-1]); end
        end
        vec++; if (r1_cnt - c1 !== want_r1) begin errs++; $display("FAIL t2_ready1_cycles got %0d want %0d", r1_cnt - c1, want_r1); end
    endtask

    task automatic test_issue_stall();
        drive0(UOP_ROR, 32'hA5A5_0F0F, 32'd4, 6'd12);
        bus.req0_valid_i = 1'b1;
        bus.cu_ready_i = 1'b0;
        cyc();
        bus.req0_valid_i = 1'b0;
        drive0(UOP_ROL, 32'hFFFF_FFFF, 32'd9, 6'd1);
        for (int i = 0; i < 5; i++) begin
            vec++; if (bus.cu_valid_o !== 1'b1) begin errs++; $display("FAIL t3_cu_valid%0d got %b want 1", i, bus.cu_valid_o); end
            vec++; if (bus.cu_a_o !== 32'hA5A5_0F0F || bus.cu_b_o !== 32'd4) begin errs++; $display("FAIL t3_payload%0d got %h/%h want a5a50f0f/4", i, bus.cu_a_o, bus.cu_b_o); end
            if (i == 4) bus.cu_ready_i = 1'b1;
            cyc();
        end
        vec++; if (bus.cu_valid_o !== 1'b0) begin errs++; $display("FAIL t3_wait_cu_valid got %b want 0", bus.cu_valid_o); end
        bus.cu_done_i = 1'b1; bus.cu_result_i = 32'h5A5A_F0F0;
        cyc();
        bus.cu_done_i = 1'b0;
        vec++; if (bus.wb_data_o !== 32'h5A5A_F0F0) begin errs++; $display("FAIL t3_wb_data got %h want 5a5af0f0", bus.wb_data_o); end
        cyc();
    endtask

    task automatic test_flush_wait();
        drive0(UOP_REV8, 32'h1234, 32'h0, 6'd9);
        drive1(UOP_ORCB, 32'h4321, 32'h0, 6'd21);
        bus.req0_valid_i = 1'b1;
        cyc();
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b1;
        cyc();
        bus.flush_i = 1'b1;
        #1;
        vec++; if (bus.req1_ready_o !== 1'b0) begin errs++; $display("FAIL t4_ready1_flush got %b want 0", bus.req1_ready_o); end
        cyc();
        bus.flush_i = 1'b0;
        vec++; if (bus.req1_ready_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin errs++; $display("FAIL t4_drain1 got r1=%b wb=%b want 0/0", bus.req1_ready_o, bus.wb_valid_o); end
        cyc();
        bus.cu_done_i = 1'b1; bus.cu_result_i = 32'h0000_DEAD;
        #1;
        vec++; if (bus.req1_ready_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin errs++; $display("FAIL t4_drain2 got r1=%b wb=%b want 0/0", bus.req1_ready_o, bus.wb_valid_o); end
        cyc();
        bus.cu_done_i = 1'b0;
        vec++; if (bus.wb_valid_o !== 1'b0 || bus.req1_ready_o !== 1'b1) begin errs++; $display("FAIL t4_idle got wb=%b r1=%b want 0/1", bus.wb_valid_o, bus.req1_ready_o); end
        vec++; if (bus.wb_data_o !== 32'h5A5A_F0F0) begin errs++; $display("FAIL t4_stale_data got %h want 5a5af0f0", bus.wb_data_o); end
        cyc();
        bus.req1_valid_i = 1'b0;
        bus.cu_done_i = 1'b1; bus.cu_result_i = 32'h0000_1234;
        cyc();
        bus.cu_done_i = 1'b0;
        vec++; if (bus.wb_tag_o !== 6'd21 || bus.wb_data_o !== 32'h1234) begin errs++; $display("FAIL t4_next_op got %0d/%h want 21/1234", bus.wb_tag_o, bus.wb_data_o); end
        cyc();
    endtask

    task automatic test_wb_stall();
        drive0(UOP_CLZ, 32'h0000_0010, 32'h0, 6'd3);
        drive1(UOP_CTZ, 32'h0000_0100, 32'h0, 6'd4);
        bus.req0_valid_i = 1'b1;
        cyc();
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b1;
        bus.cu_done_i = 1'b1; bus.cu_result_i = 32'd27;
        bus.wb_ready_i = 1'b0;
        cyc();
        bus.cu_done_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vec++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 6'd3 || bus.wb_data_o !== 32'd27) begin errs++; $display("FAIL t5_hold%0d got %b/%0d/%0d want 1/3/27", i, bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o); end
            vec++; if (bus.req1_ready_o !== 1'b0) begin errs++; $display("FAIL t5_ready1_%0d got %b want 0", i, bus.req1_ready_o); end
            cyc();
        end
        bus.wb_ready_i = 1'b1;
        #1;
        vec++; if (bus.wb_valid_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin errs++; $display("FAIL t5_accept got wb=%b r1=%b want 1/0", bus.wb_valid_o, bus.req1_ready_o); end
        cyc();
        vec++; if (bus.wb_valid_o !== 1'b0 || bus.req1_ready_o !== 1'b1) begin errs++; $display("FAIL t5_after got wb=%b r1=%b want 0/1", bus.wb_valid_o, bus.req1_ready_o); end
        cyc();
        bus.req1_valid_i = 1'b0;
        bus.cu_done_i = 1'b1; bus.cu_result_i = 32'd8;
        cyc();
        bus.cu_done_i = 1'b0;
        cyc();
    endtask

    task automatic test_flush_issue_wb();
        drive0(UOP_CPOP, 32'h3, 32'h0, 6'd2);
        bus.req0_valid_i = 1'b1;
        cyc();
        bus.req0_valid_i = 1'b0;
        bus.cu_ready_i = 1'b0; bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0; bus.cu_ready_i = 1'b1;
        vec++; if (bus.cu_valid_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin errs++; $display("FAIL t7_issue_flush got cu=%b wb=%b want 0/0", bus.cu_valid_o, bus.wb_valid_o); end
        bus.req0_valid_i = 1'b1;
        cyc();
        bus.req0_valid_i = 1'b0;
        bus.cu_done_i = 1'b1; bus.cu_result_i = 32'd2;
        cyc();
        bus.cu_done_i = 1'b0; bus.wb_ready_i = 1'b0;
        vec++; if (bus.wb_valid_o !== 1'b1) begin errs++; $display("FAIL t7_wb_before got %b want 1", bus.wb_valid_o); end
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0; bus.wb_ready_i = 1'b1;
        vec++; if (bus.wb_valid_o !== 1'b0) begin errs++; $display("FAIL t7_wb_flush got %b want 0", bus.wb_valid_o); end
    endtask

    task automatic test_reset_in_wait();
        drive0(UOP_ROR, 32'hCAFE_0001, 32'd3, 6'd7);
        drive1(UOP_ROL, 32'hBEEF_0002, 32'd5, 6'd8);
        bus.req0_valid_i = 1'b1;
        cyc();
        bus.req0_valid_i = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        vec++; if (bus.cu_valid_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin errs++; $display("FAIL t6_valids got cu=%b wb=%b want 0/0", bus.cu_valid_o, bus.wb_valid_o); end
        vec++; if (bus.cu_a_o !== 32'h0 || bus.cu_b_o !== 32'h0 || bus.cu_uop_o !== 7'h0) begin errs++; $display("FAIL t6_payload got %h/%h/%h want 0", bus.cu_uop_o, bus.cu_a_o, bus.cu_b_o); end
        vec++; if (bus.wb_tag_o !== 6'h0 || bus.wb_data_o !== 32'h0) begin errs++; $display("FAIL t6_wb got %h/%h want 0/0", bus.wb_tag_o, bus.wb_data_o); end
        cyc();
        rst = 1'b0;
        cyc();
        bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
        #1;
        vec++; if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin errs++; $display("FAIL t6_pointer got r0=%b r1=%b want 1/0", bus.req0_ready_o, bus.req1_ready_o); end
        cyc();
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        bus.cu_done_i = 1'b1; bus.cu_result_i = 32'd1;
        cyc();
        bus.cu_done_i = 1'b0;
        vec++; if (bus.wb_tag_o !== 6'd7 || bus.wb_data_o !== 32'd1) begin errs++; $display("FAIL t6_after got %0d/%0d want 7/1", bus.wb_tag_o, bus.wb_data_o); end
        cyc();
    endtask

    initial begin
        bus.flush_i = 1'b0;
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        drive0(7'h0, 32'h0, 32'h0, 6'h0);
        drive1(7'h0, 32'h0, 32'h0, 6'h0);
        bus.cu_ready_i = 1'b1; bus.cu_done_i = 1'b0;
        bus.cu_result_i = 32'h0; bus.wb_ready_i = 1'b1;
        test_reset();
        test_single_lane0();
        test_arbitration();
        test_issue_stall();
        test_flush_wait();
        test_wb_stall();
        test_flush_issue_wb();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
